// File: rtl/memory_response_latency_simulator_if.sv
// memory_response_latency_simulator_if: push/response bus of the memory response latency model
//   master : memory/consumer side (drives push_*, resp_ready)
//   slave  : the latency model (drives push_ready, resp_*, occupancy)
interface memory_response_latency_simulator_if #(
   parameter int QUEUE_SIZE = 8,
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 4
);
   logic                          push_valid;
   logic                          push_ready;
   logic [DATA_WIDTH-1:0]         push_data;
   logic [TAG_WIDTH-1:0]          push_tag;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic [TAG_WIDTH-1:0]          resp_tag;
   logic [$clog2(QUEUE_SIZE):0]   occupancy;
   modport master (
      output push_valid, push_data, push_tag, resp_ready,
      input  push_ready, resp_valid, resp_data, resp_tag, occupancy
   );
   modport slave (
      input  push_valid, push_data, push_tag, resp_ready,
      output push_ready, resp_valid, resp_data, resp_tag, occupancy
   );
endinterface

// File: rtl/memory_response_latency_simulator.sv
// memory_response_latency_simulator: in-order response FIFO releasing each entry after a pseudo-random delay
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : push_valid/push_ready/push_data/push_tag in, resp_valid/resp_ready/resp_data/resp_tag out,
//                 occupancy = current entry count
//   MEM_RESP_SIM_FIXED_LATENCY_EN : when defined, every entry waits FLUCTUATION_RANGE-1 cycles and the
//                 random generator stays at its seed
//   Simulation-only: building with RSD_SYNTHESIS defined stops elaboration.
module memory_response_latency_simulator #(
   parameter int          QUEUE_SIZE        = 8,
   parameter int          DATA_WIDTH        = 64,
   parameter int          TAG_WIDTH         = 4,
   parameter int          FLUCTUATION_RANGE = 8,
   parameter logic [31:0] RAND_SEED         = 32'h0000_0001
) (
   input logic clk,
   input logic rst,
   memory_response_latency_simulator_if.slave bus
);
   localparam int PW = $clog2(QUEUE_SIZE);
   typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;
`ifdef RSD_SYNTHESIS
   if (1) begin : g_sim_only
      $error("memory_response_latency_simulator is a simulation-only model");
   end
`endif
   if (RAND_SEED == 32'd0) begin : g_bad_seed
      $error("RAND_SEED must be nonzero");
   end
   if (QUEUE_SIZE < 2 || (QUEUE_SIZE & (QUEUE_SIZE - 1)) != 0) begin : g_bad_depth
      $error("QUEUE_SIZE must be a power of two >= 2");
   end
   if (FLUCTUATION_RANGE < 1) begin : g_bad_range
      $error("FLUCTUATION_RANGE must be >= 1");
   end
   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] data_q [QUEUE_SIZE];
   logic [TAG_WIDTH-1:0]  tag_q  [QUEUE_SIZE];
   logic [PW-1:0]         head, tail;
   logic [PW:0]           occ;
   logic [31:0]           count, rnd, target;
   logic                  push, pop, resp_valid;
   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      return y ^ (y << 5);
   endfunction
`ifdef MEM_RESP_SIM_FIXED_LATENCY_EN
   assign target = 32'(FLUCTUATION_RANGE - 1);
`else
   assign target = rnd % 32'(FLUCTUATION_RANGE);
`endif
   assign push           = bus.push_valid && bus.push_ready;
   assign pop            = resp_valid && bus.resp_ready;
   assign bus.push_ready = occ != (PW + 1)'(QUEUE_SIZE);
   assign bus.occupancy  = occ;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_data  = data_q[head];
   assign bus.resp_tag   = tag_q[head];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= (state == WAIT && count != target) ? count + 32'd1 : 32'd0;
      end
   // After a pop the next state looks only at what remains; an entry pushed in the same cycle
   // is picked up one cycle later through IDLE.
   always_comb begin
      state_nxt = state == IDLE ? (occ != '0 ? WAIT : IDLE) :
                  state == WAIT ? (count == target ? PRESENT : WAIT) :
                  (bus.resp_ready ? (occ != (PW + 1)'(1) ? WAIT : IDLE) : PRESENT);
   end
   always_comb begin
      resp_valid = state == PRESENT;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         rnd  <= RAND_SEED;
      end else begin
         head <= pop ? head + 1'b1 : head;
         tail <= push ? tail + 1'b1 : tail;
         occ  <= occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
`ifndef MEM_RESP_SIM_FIXED_LATENCY_EN
         rnd  <= pop ? xorshift32(rnd) : rnd;
`endif
      end
   always_ff @(posedge clk)
      if (push) begin
         data_q[tail] <= bus.push_data;
         tag_q[tail]  <= bus.push_tag;
      end
   a_valid_held: assert property (@(posedge clk) disable iff (rst)
      resp_valid && !bus.resp_ready |=> resp_valid);
endmodule

// File: tb/tb_memory_response_latency_simulator.sv
// tb_memory_response_latency_simulator: directed checks of latency, ordering, full handling and reset
module tb_memory_response_latency_simulator;
   localparam int QS = 8;
   localparam int DW = 64;
   localparam int TW = 4;
`ifdef MEM_RESP_SIM_FIXED_LATENCY_EN
   localparam int          T0   = 7;
   localparam int          T1   = 7;
   localparam logic [31:0] RND1 = 32'h0000_0001;
`else
   localparam int          T0   = 1;
   localparam int          T1   = 1;
   localparam logic [31:0] RND1 = 32'h0004_2021;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   memory_response_latency_simulator_if #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
   memory_response_latency_simulator #(
      .QUEUE_SIZE(QS), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
      .FLUCTUATION_RANGE(8), .RAND_SEED(32'h0000_0001)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.push_valid = 1'b0;
      bus.push_data  = '0;
      bus.push_tag   = '0;
      bus.resp_ready = 1'b0;
   endtask
   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask
   task automatic push_one(input int tag, input logic [DW-1:0] data);
      bus.push_valid = 1'b1;
      bus.push_tag   = TW'(tag);
      bus.push_data  = data;
      step();
      bus.push_valid = 1'b0;
   endtask
   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.resp_valid && k < 40) begin
         step();
         k++;
      end
      n_cmp++;
      if (bus.resp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: resp_valid got %b want 1 within 40 cycles", name, bus.resp_valid);
      end
   endtask
   task automatic test_reset();
      apply_reset();
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
      n_cmp++; if (bus.push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready: got %b want 1", bus.push_ready); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
   endtask
   task automatic test_single(input string name);
      bus.resp_ready = 1'b1;
      push_one(3, 64'hAA);
      n_cmp++; if (bus.occupancy !== 4'd1) begin n_bad++; $display("FAIL %s_occ: got %0d want 1", name, bus.occupancy); end
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid edge 0: got %b want 0", name, bus.resp_valid); end
      for (int e = 1; e <= 2 + T0; e++) begin
         step();
         n_cmp++;
         if (bus.resp_valid !== (e == 2 + T0)) begin
            n_bad++;
            $display("FAIL %s_valid edge %0d: got %b want %b", name, e, bus.resp_valid, e == 2 + T0);
         end
      end
      n_cmp++; if (bus.resp_tag !== 4'd3) begin n_bad++; $display("FAIL %s_tag: got %0d want 3", name, bus.resp_tag); end
      n_cmp++; if (bus.resp_data !== 64'hAA) begin n_bad++; $display("FAIL %s_data: got %h want aa", name, bus.resp_data); end
      step();
      bus.resp_ready = 1'b0;
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_after_pop_valid: got %b want 0", name, bus.resp_valid); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL %s_after_pop_occ: got %0d want 0", name, bus.occupancy); end
      n_cmp++; if (dut.rnd !== RND1) begin n_bad++; $display("FAIL %s_rand: got %h want %h", name, dut.rnd, RND1); end
   endtask
   task automatic test_back_to_back();
      int got[$];
      int hs[$];
      int peak = 0;
      apply_reset();
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         bus.push_valid = c < 4;
         bus.push_tag   = TW'(c);
         bus.push_data  = 64'hB00 + 64'(c);
         if (bus.resp_valid && bus.resp_ready) begin
            got.push_back(int'(bus.resp_tag));
            hs.push_back(c);
         end
         step();
         if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
      end
      idle_inputs();
      n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         n_cmp++; if (got[i] != i) begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, got[i], i); end
      end
      if (hs.size() >= 2) begin
         n_cmp++; if (hs[1] - hs[0] != 2 + T1) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", hs[1] - hs[0], 2 + T1); end
      end
      n_cmp++; if (peak != 4) begin n_bad++; $display("FAIL b2b_peak: got %0d want 4", peak); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL b2b_end_occ: got %0d want 0", bus.occupancy); end
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid: got %b want 0", bus.resp_valid); end
   endtask
   task automatic test_full();
      int exp_tag = 2;
      apply_reset();
      for (int i = 0; i < 7; i++) push_one(i, 64'h100 + 64'(i));
      wait_valid("full_first_valid");
      n_cmp++; if (bus.occupancy !== 4'd7) begin n_bad++; $display("FAIL full_occ7: got %0d want 7", bus.occupancy); end
      n_cmp++; if (bus.push_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready7: got %b want 1", bus.push_ready); end
      n_cmp++; if (bus.resp_tag !== 4'd0) begin n_bad++; $display("FAIL full_head_tag: got %0d want 0", bus.resp_tag); end
      bus.resp_ready = 1'b1;
      push_one(7, 64'h107);
      bus.resp_ready = 1'b0;
      n_cmp++; if (bus.occupancy !== 4'd7) begin n_bad++; $display("FAIL full_push_pop_occ: got %0d want 7", bus.occupancy); end
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL full_push_pop_valid: got %b want 0", bus.resp_valid); end
      push_one(8, 64'h108);
      n_cmp++; if (bus.occupancy !== 4'd8) begin n_bad++; $display("FAIL full_occ8: got %0d want 8", bus.occupancy); end
      n_cmp++; if (bus.push_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready8: got %b want 0", bus.push_ready); end
      wait_valid("full_second_valid");
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (bus.resp_valid !== 1'b1 || bus.resp_tag !== 4'd1 || bus.resp_data !== 64'h101 || bus.push_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_hold[%0d]: valid %b tag %0d data %h ready %b want 1 1 101 0",
                     k, bus.resp_valid, bus.resp_tag, bus.resp_data, bus.push_ready);
         end
         step();
      end
      bus.push_valid = 1'b1;
      bus.push_tag   = 4'd9;
      bus.push_data  = 64'h109;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      n_cmp++; if (bus.occupancy !== 4'd7) begin n_bad++; $display("FAIL full_pop_blocked_push: got %0d want 7", bus.occupancy); end
      step();
      bus.push_valid = 1'b0;
      n_cmp++; if (bus.occupancy !== 4'd8) begin n_bad++; $display("FAIL full_refill: got %0d want 8", bus.occupancy); end
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 300 && exp_tag <= 9; c++) begin
         if (bus.resp_valid) begin
            n_cmp++;
            if (bus.resp_tag !== TW'(exp_tag) || bus.resp_data !== 64'h100 + 64'(exp_tag)) begin
               n_bad++;
               $display("FAIL full_drain: tag %0d data %h want tag %0d data %h",
                        bus.resp_tag, bus.resp_data, exp_tag, 64'h100 + 64'(exp_tag));
            end
            exp_tag++;
         end
         step();
      end
      idle_inputs();
      n_cmp++; if (exp_tag != 10) begin n_bad++; $display("FAIL full_drain_count: got %0d want 10", exp_tag); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL full_drain_occ: got %0d want 0", bus.occupancy); end
   endtask
   task automatic test_reset_mid_present();
      apply_reset();
      for (int i = 0; i < 3; i++) push_one(i, 64'h200 + 64'(i));
      wait_valid("midrst_valid");
      n_cmp++; if (bus.occupancy !== 4'd3) begin n_bad++; $display("FAIL midrst_occ_before: got %0d want 3", bus.occupancy); end
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_drop: got %b want 0", bus.resp_valid); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL midrst_occ: got %0d want 0", bus.occupancy); end
      n_cmp++; if (bus.push_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_push_ready: got %b want 1", bus.push_ready); end
      step();
      rst = 1'b0;
      test_single("midrst_single");
   endtask
   task automatic test_stream();
      int  sent = 0;
      int  rcvd = 0;
      logic do_push, do_pop;
      apply_reset();
      for (int c = 0; c < 3000 && rcvd < 20; c++) begin
         bus.push_valid = sent < 20 && $urandom_range(0, 3) != 0;
         bus.push_tag   = TW'(sent);
         bus.push_data  = 64'hC0DE_0000 + 64'(sent);
         bus.resp_ready = $urandom_range(0, 2) != 0;
         do_push = bus.push_valid && bus.push_ready;
         do_pop  = bus.resp_valid && bus.resp_ready;
         if (do_pop) begin
            n_cmp++;
            if (bus.resp_tag !== TW'(rcvd) || bus.resp_data !== 64'hC0DE_0000 + 64'(rcvd)) begin
               n_bad++;
               $display("FAIL stream[%0d]: tag %0d data %h want tag %0d data %h",
                        rcvd, bus.resp_tag, bus.resp_data, rcvd % 16, 64'hC0DE_0000 + 64'(rcvd));
            end
            rcvd++;
         end
         step();
         if (do_push) sent++;
      end
      idle_inputs();
      n_cmp++; if (rcvd != 20) begin n_bad++; $display("FAIL stream_rcvd: got %0d want 20", rcvd); end
      n_cmp++; if (sent != 20) begin n_bad++; $display("FAIL stream_sent: got %0d want 20", sent); end
      n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL stream_occ: got %0d want 0", bus.occupancy); end
      n_cmp++; if (dut.tail !== 3'd4) begin n_bad++; $display("FAIL stream_tail_wrap: got %0d want 4", dut.tail); end
   endtask
   initial begin
      idle_inputs();
      test_reset();
      test_single("single");
      test_back_to_back();
      test_full();
      test_reset_mid_present();
      test_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
